// File: rtl/keypad_scan_4x4.sv
// 4x4 matrix keypad scanner with frame-based press/release debouncing.
// Optional auto-repeat of key_valid while held: define KEYPAD_AUTOREPEAT_EN.
module keypad_scan_4x4 #(
  parameter int ROW_CYCLES    = 100000,
  parameter int DEB_FRAMES    = 5,
  parameter int REPEAT_FRAMES = 50
) (
  input  logic       clk,
  input  logic       sys_rst_n,
  input  logic [3:0] col_in,
  output logic [3:0] row_out,
  output logic       key_pressed,
  output logic [3:0] key_data,
  output logic       key_valid
);

  localparam int DW = $clog2(ROW_CYCLES) + 1;
  localparam int CW = $clog2(DEB_FRAMES) + 1;
  localparam logic [DW-1:0] DWELL_LAST = DW'(ROW_CYCLES - 1);
  localparam logic [CW-1:0] DEB_LAST   = CW'(DEB_FRAMES - 1);

  typedef enum logic [1:0] {IDLE, DEB_PRESS, PRESSED, DEB_REL} state_t;

  logic [3:0]    col_meta_r;
  logic [3:0]    col_sync_r;
  logic [1:0]    row_idx_r;
  logic [1:0]    row_next_s;
  logic [DW-1:0] dwell_r;
  logic          acc_hit_r;
  logic [3:0]    acc_code_r;
  logic          frame_done_r;
  logic          frame_hit_r;
  logic [3:0]    frame_code_r;
  logic          row_hit_s;
  logic [1:0]    row_col_s;
  logic [3:0]    row_code_s;
  state_t        state_r;
  logic [3:0]    cand_r;
  logic [CW-1:0] cnt_r;
`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int RW = $clog2(REPEAT_FRAMES) + 1;
  localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_FRAMES - 1);
  logic [RW-1:0] rep_r;
`endif

  // Key index r*4+c to code; row 3 carries E,0,F,D
  function automatic logic [3:0] key_code(input logic [3:0] idx);
    logic [3:0] code;
    case (idx)
      4'd0:    code = 4'h1;
      4'd1:    code = 4'h2;
      4'd2:    code = 4'h3;
      4'd3:    code = 4'hA;
      4'd4:    code = 4'h4;
      4'd5:    code = 4'h5;
      4'd6:    code = 4'h6;
      4'd7:    code = 4'hB;
      4'd8:    code = 4'h7;
      4'd9:    code = 4'h8;
      4'd10:   code = 4'h9;
      4'd11:   code = 4'hC;
      4'd12:   code = 4'hE;
      4'd13:   code = 4'h0;
      4'd14:   code = 4'hF;
      4'd15:   code = 4'hD;
      default: code = 4'h0;
    endcase
    return code;
  endfunction

  // Lowest closed column on the currently driven row
  always_comb begin
    row_hit_s = 1'b0;
    row_col_s = 2'd0;
    if (!col_sync_r[0]) begin
      row_hit_s = 1'b1;
      row_col_s = 2'd0;
    end else if (!col_sync_r[1]) begin
      row_hit_s = 1'b1;
      row_col_s = 2'd1;
    end else if (!col_sync_r[2]) begin
      row_hit_s = 1'b1;
      row_col_s = 2'd2;
    end else if (!col_sync_r[3]) begin
      row_hit_s = 1'b1;
      row_col_s = 2'd3;
    end else begin
      row_hit_s = 1'b0;
    end
    row_code_s = key_code({row_idx_r, row_col_s});
    row_next_s = row_idx_r + 2'd1;
  end

  // Column synchroniser, row dwell/scan and per-frame hit accumulation
  always_ff @(posedge clk) begin
    if (!sys_rst_n) begin
      col_meta_r   <= 4'h0;
      col_sync_r   <= 4'h0;
      row_idx_r    <= 2'd0;
      row_out      <= 4'b1110;
      dwell_r      <= '0;
      acc_hit_r    <= 1'b0;
      acc_code_r   <= 4'h0;
      frame_done_r <= 1'b0;
      frame_hit_r  <= 1'b0;
      frame_code_r <= 4'h0;
    end else begin
      col_meta_r   <= col_in;
      col_sync_r   <= col_meta_r;
      frame_done_r <= 1'b0;
      if (dwell_r == DWELL_LAST) begin
        dwell_r   <= '0;
        row_idx_r <= row_next_s;
        row_out   <= ~(4'b0001 << row_next_s);
        if (row_idx_r == 2'd3) begin
          frame_done_r <= 1'b1;
          frame_hit_r  <= acc_hit_r | row_hit_s;
          frame_code_r <= acc_hit_r ? acc_code_r : row_code_s;
          acc_hit_r    <= 1'b0;
          acc_code_r   <= 4'h0;
        end else if (!acc_hit_r && row_hit_s) begin
          acc_hit_r  <= 1'b1;
          acc_code_r <= row_code_s;
        end else begin
          acc_hit_r <= acc_hit_r;
        end
      end else begin
        dwell_r <= dwell_r + DW'(1);
      end
    end
  end

  // Debounce FSM, stepped once per completed frame
  always_ff @(posedge clk) begin
    if (!sys_rst_n) begin
      state_r     <= IDLE;
      cand_r      <= 4'h0;
      cnt_r       <= '0;
      key_pressed <= 1'b0;
      key_data    <= 4'h0;
      key_valid   <= 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
      rep_r       <= '0;
`endif
    end else begin
      key_valid <= 1'b0;
      if (frame_done_r) begin
        case (state_r)
          IDLE: begin
            if (frame_hit_r) begin
              state_r <= DEB_PRESS;
              cand_r  <= frame_code_r;
              cnt_r   <= CW'(1);
            end else begin
              state_r <= IDLE;
            end
          end
          DEB_PRESS: begin
            if (!frame_hit_r) begin
              state_r <= IDLE;
            end else if (frame_code_r != cand_r) begin
              cand_r <= frame_code_r;
              cnt_r  <= CW'(1);
            end else if (cnt_r == DEB_LAST) begin
              state_r     <= PRESSED;
              key_data    <= cand_r;
              key_pressed <= 1'b1;
              key_valid   <= 1'b1;
`ifdef KEYPAD_AUTOREPEAT_EN
              rep_r       <= '0;
`endif
            end else begin
              cnt_r <= cnt_r + CW'(1);
            end
          end
          PRESSED: begin
            if (!frame_hit_r || frame_code_r != key_data) begin
              state_r <= DEB_REL;
              cnt_r   <= CW'(1);
`ifdef KEYPAD_AUTOREPEAT_EN
              rep_r   <= '0;
`endif
            end else begin
`ifdef KEYPAD_AUTOREPEAT_EN
              if (rep_r == REP_LAST) begin
                key_valid <= 1'b1;
                rep_r     <= '0;
              end else begin
                rep_r <= rep_r + RW'(1);
              end
`else
              state_r <= PRESSED;
`endif
            end
          end
          DEB_REL: begin
            // A different key here only counts toward release
            if (frame_hit_r && frame_code_r == key_data) begin
              state_r <= PRESSED;
`ifdef KEYPAD_AUTOREPEAT_EN
              rep_r   <= '0;
`endif
            end else if (cnt_r == DEB_LAST) begin
              state_r     <= IDLE;
              key_pressed <= 1'b0;
            end else begin
              cnt_r <= cnt_r + CW'(1);
            end
          end
          default: state_r <= IDLE;
        endcase
      end else begin
        state_r <= state_r;
      end
    end
  end

endmodule

// File: tb/tb_keypad_scan_4x4.sv
// Scoreboard bench for keypad_scan_4x4: a switch-matrix model drives col_in
// from row_out, expected key codes are queued and popped on each key_valid.
module tb_keypad_scan_4x4;

  localparam int ROW_CYCLES    = 8;
  localparam int DEB_FRAMES    = 3;
  localparam int REPEAT_FRAMES = 4;
  localparam int FRAME         = 4 * ROW_CYCLES;

  logic       clk = 1'b0;
  logic       sys_rst_n = 1'b0;
  logic [3:0] col_in;
  logic [3:0] row_out;
  logic       key_pressed;
  logic [3:0] key_data;
  logic       key_valid;

  logic [15:0] keys = 16'h0000;
  int total = 0;
  int bad = 0;
  int cycle = 0;
  int strobes = 0;
  logic [3:0] exp_q[$];
  int strobe_times[$];

  keypad_scan_4x4 #(
    .ROW_CYCLES(ROW_CYCLES),
    .DEB_FRAMES(DEB_FRAMES),
    .REPEAT_FRAMES(REPEAT_FRAMES)
  ) dut (
    .clk(clk),
    .sys_rst_n(sys_rst_n),
    .col_in(col_in),
    .row_out(row_out),
    .key_pressed(key_pressed),
    .key_data(key_data),
    .key_valid(key_valid)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  // Switch matrix: a closed key on a driven (low) row pulls its column low
  always_comb begin
    col_in = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (!row_out[r] && keys[r*4+c]) col_in[c] = 1'b0;
      end
    end
  end

  // Scoreboard: every strobe must match the oldest queued expectation
  always @(negedge clk) begin
    if (key_valid) begin
      logic [3:0] e;
      strobes = strobes + 1;
      strobe_times.push_back(cycle);
      total = total + 1;
      if (exp_q.size() == 0) begin
        bad = bad + 1;
        $display("FAIL unexpected_strobe: key_data=%h at cycle %0d, none expected", key_data, cycle);
      end else begin
        e = exp_q.pop_front();
        if (key_data !== e) begin
          bad = bad + 1;
          $display("FAIL strobe_code: got %h want %h", key_data, e);
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [15:0] k);
    @(posedge clk);
    #1 sys_rst_n = 1'b0;
    keys = k;
    @(posedge clk);
    #1 sys_rst_n = 1'b1;
  endtask

  task automatic check_bit(input string name, input logic got, input logic want);
    total = total + 1;
    if (got !== want) begin
      bad = bad + 1;
      $display("FAIL %s: got %b want %b", name, got, want);
    end
  endtask

  task automatic check_int(input string name, input int got, input int want);
    total = total + 1;
    if (got != want) begin
      bad = bad + 1;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  task automatic test_reset();
    do_reset(16'h0000);
    check_int("reset_row_out", row_out, 4'b1110);
    check_bit("reset_key_pressed", key_pressed, 1'b0);
    check_int("reset_key_data", key_data, 0);
    check_bit("reset_key_valid", key_valid, 1'b0);
  endtask

  task automatic test_single_press();
    int s0;
    s0 = strobes;
    exp_q.push_back(4'h6);
    do_reset(16'h0040);
    step(4 * FRAME + 3);
    check_int("press_strobes", strobes - s0, 1);
    check_bit("press_key_pressed", key_pressed, 1'b1);
    check_int("press_key_data", key_data, 4'h6);
  endtask

  task automatic test_release();
    int s0;
    s0 = strobes;
    keys = 16'h0000;
    step(2 * FRAME);
    check_bit("release_still_held", key_pressed, 1'b1);
    step(4 * FRAME);
    check_bit("release_key_pressed", key_pressed, 1'b0);
    check_int("release_key_data", key_data, 4'h6);
    check_int("release_strobes", strobes - s0, 0);
    check_int("release_pending", exp_q.size(), 0);
  endtask

  task automatic test_bounce();
    int s0;
    s0 = strobes;
    do_reset(16'h0001);
    step(FRAME);
    keys = 16'h0000;
    step(FRAME);
    keys = 16'h0001;
    step(FRAME);
    keys = 16'h0000;
    step(6 * FRAME);
    check_int("bounce_strobes", strobes - s0, 0);
    check_bit("bounce_key_pressed", key_pressed, 1'b0);
    check_int("bounce_key_data", key_data, 0);
  endtask

  task automatic test_priority();
    exp_q.push_back(4'hA);
    do_reset(16'h0108);
    step(5 * FRAME);
    check_int("priority_key_data", key_data, 4'hA);
    check_bit("priority_key_pressed", key_pressed, 1'b1);
    check_int("priority_pending", exp_q.size(), 0);
  endtask

  task automatic test_key_change();
    int s0;
    s0 = strobes;
    exp_q.push_back(4'h6);
    do_reset(16'h0040);
    step(5 * FRAME);
    exp_q.push_back(4'h9);
    keys = 16'h0400;
    step(8 * FRAME);
    check_int("change_strobes", strobes - s0, 2);
    check_int("change_key_data", key_data, 4'h9);
    check_bit("change_key_pressed", key_pressed, 1'b1);
    check_int("change_pending", exp_q.size(), 0);
  endtask

  task automatic test_reset_mid_debounce();
    int s0;
    exp_q.push_back(4'h5);
    do_reset(16'h0020);
    step(2 * FRAME + 8);
    s0 = strobes;
    sys_rst_n = 1'b0;
    step(1);
    check_int("midrst_row_out", row_out, 4'b1110);
    check_bit("midrst_key_pressed", key_pressed, 1'b0);
    check_int("midrst_key_data", key_data, 0);
    check_bit("midrst_key_valid", key_valid, 1'b0);
    sys_rst_n = 1'b1;
    step(2 * FRAME + 26);
    check_int("midrst_early_strobes", strobes - s0, 0);
    check_bit("midrst_early_pressed", key_pressed, 1'b0);
    step(2 * FRAME - 23);
    check_int("midrst_strobes", strobes - s0, 1);
    check_int("midrst_key_data", key_data, 4'h5);
  endtask

  task automatic test_autorepeat();
    int s0;
    int n0;
    s0 = strobes;
    n0 = strobe_times.size();
`ifdef KEYPAD_AUTOREPEAT_EN
    for (int i = 0; i < 5; i++) exp_q.push_back(4'h5);
`else
    exp_q.push_back(4'h5);
`endif
    do_reset(16'h0020);
    step(20 * FRAME + 4);
`ifdef KEYPAD_AUTOREPEAT_EN
    check_int("repeat_strobes", strobes - s0, 5);
    for (int i = n0 + 1; i < strobe_times.size(); i++)
      check_int("repeat_interval", strobe_times[i] - strobe_times[i-1], 4 * FRAME);
`else
    check_int("repeat_strobes", strobes - s0, 1);
`endif
    check_bit("repeat_key_pressed", key_pressed, 1'b1);
    check_int("repeat_pending", exp_q.size(), 0);
  endtask

  initial begin
    test_reset();
    test_single_press();
    test_release();
    test_bounce();
    test_priority();
    test_key_change();
    test_reset_mid_debounce();
    test_autorepeat();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
